// File: rtl/gcm_phase_merger_pkg.sv
// Shared phase encodings and sequence-tracking states for the GCM phase merger.
package gcm_phase_pkg;

  localparam logic [3:0] PKT_FIRST_WORD  = 4'd1;
  localparam logic [3:0] PKT_SECOND_WORD = 4'd2;
  localparam logic [3:0] PKT_INNER_WORD  = 4'd4;

  typedef enum logic [1:0] {
    IDLE,
    EXP_SECOND,
    EXP_INNER
  } seq_state_t;

endpackage

// File: rtl/gcm_phase_merger_sync_fifo.sv
// Show-ahead synchronous FIFO; head entry is visible whenever o_empty is low.
module gcm_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset; o_empty masks it.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/gcm_phase_merger.sv
// Merges packet words with keystream by phase, checks phase ordering and
// queues {last, word_idx, cipher, text} entries for the GHASH/output stage.
module gcm_phase_merger
  import gcm_phase_pkg::*;
#(
  parameter int TEXT_W = 289,
  parameter int KS_W   = 256,
  parameter int KEEP_W = TEXT_W - KS_W / 2,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          i_state,
  input  logic                i_last,
  input  logic [TEXT_W-1:0]   i_text,
  input  logic [KS_W-1:0]     i_cipher,
  input  logic                i_valid,
  output logic                o_in_ready,
  output logic [TEXT_W-1:0]   o_text,
  output logic [KS_W/2-1:0]   o_cipher,
  output logic                o_last,
  output logic [CNT_W-1:0]    o_word_idx,
  output logic                o_valid,
  input  logic                i_out_ready,
  output logic                o_seq_err,
  output logic [CNT_W-1:0]    o_pkt_cnt
);

  localparam int HALF_W = KS_W / 2;
  localparam int ENT_W  = 1 + CNT_W + HALF_W + TEXT_W;

  if (KEEP_W != TEXT_W - KS_W / 2) begin : g_bad_keep
    $error("KEEP_W must equal TEXT_W - KS_W/2");
  end
  if ((KS_W % 2) != 0) begin : g_bad_ks
    $error("KS_W must be even");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end

  function automatic logic [TEXT_W-1:0] merge_text(input logic [3:0]        st,
                                                   input logic [TEXT_W-1:0] txt,
                                                   input logic [KS_W-1:0]   ks);
    if (st == PKT_FIRST_WORD) return txt;
    return {ks[KS_W-1:HALF_W], txt[KEEP_W-1:0]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] w_push_idx;
  logic [CNT_W-1:0] r_pkt_cnt;
  logic             r_seq_err;
  logic             w_accept;
  logic             w_push;
  logic             w_first;
  logic             w_err;
  logic             w_full;
  logic             w_empty;
  logic [ENT_W-1:0] w_wdata;
  logic [ENT_W-1:0] w_head;

  assign o_in_ready = !w_full;
  assign w_accept   = i_valid && o_in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_push_idx  = '0;
    w_first     = 1'b0;
    w_err       = 1'b0;
    if (w_accept) begin
      case (i_state)
        PKT_FIRST_WORD: begin
          // A FIRST inside an open packet aborts it and starts a new one.
          w_push      = 1'b1;
          w_first     = 1'b1;
          w_err       = (r_state != IDLE);
          w_state_nxt = i_last ? IDLE : EXP_SECOND;
        end
        PKT_SECOND_WORD: begin
          if (r_state == EXP_SECOND) begin
            w_push      = 1'b1;
            w_push_idx  = sat_inc(r_idx);
            w_state_nxt = i_last ? IDLE : EXP_INNER;
          end else begin
            w_err = 1'b1;
          end
        end
        PKT_INNER_WORD: begin
          if (r_state == EXP_INNER) begin
            w_push      = 1'b1;
            w_push_idx  = sat_inc(r_idx);
            w_state_nxt = i_last ? IDLE : EXP_INNER;
          end else begin
            w_err = 1'b1;
          end
        end
        default: w_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_pkt_cnt <= '0;
      r_seq_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_seq_err <= w_err;
      if (w_push)  r_idx     <= w_push_idx;
      if (w_first) r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
    end
  end

  assign w_wdata = {i_last, w_push_idx, i_cipher[HALF_W-1:0],
                    merge_text(i_state, i_text, i_cipher)};

  gcm_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (i_out_ready),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_valid    = !w_empty;
  assign o_text     = w_empty ? '0 : w_head[TEXT_W-1:0];
  assign o_cipher   = w_empty ? '0 : w_head[TEXT_W +: HALF_W];
  assign o_word_idx = w_empty ? '0 : w_head[TEXT_W+HALF_W +: CNT_W];
  assign o_last     = w_empty ? 1'b0 : w_head[ENT_W-1];
  assign o_seq_err  = r_seq_err;
  assign o_pkt_cnt  = r_pkt_cnt;

endmodule
